// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
package mem_access_unit_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10,
    MEM_SIZE_BAD  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } mau_state_e;

  // Request fields still needed after the accept cycle.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       is_signed;
    logic [1:0] offset;
  } mem_req_t;

  function automatic logic access_error(input logic [1:0] size, input logic [1:0] off);
    return (size == MEM_SIZE_BAD) ||
           ((size == MEM_SIZE_HALF) && off[0]) ||
           ((size == MEM_SIZE_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_BYTE: return 4'b0001 << off;
      MEM_SIZE_HALF: return 4'b0011 << {off[1], 1'b0};
      default:       return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: extracts the addressed byte/halfword from a RAM word and
// sign- or zero-extends it; words pass through untouched.
module mem_load_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] data
);

  logic [1:0]            eff_off;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    // Halfwords ignore offset[0]; they are always lane-pair aligned here.
    eff_off = (size == MEM_SIZE_HALF) ? {offset[1], 1'b0} : offset;
    shifted = rdata >> {eff_off, 3'b000};
    case (size)
      MEM_SIZE_BYTE: data = {{(DATA_WIDTH-8){is_signed & shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF: data = {{(DATA_WIDTH-16){is_signed & shifted[15]}}, shifted[15:0]};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: one outstanding byte/half/word load or store to a
// synchronous RAM with one-cycle read latency. DATA_WIDTH must be 32.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  ram_en,
  output logic [3:0]            ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_W;

  mau_state_e                           state;
  mem_req_t                             req_q;
  logic [1:0]                           req_off;
  logic                                 req_err;
  logic [NUM_LANES-1:0][LANE_W-1:0]     store_data;
  logic [DATA_WIDTH-1:0]                load_data;

  assign req_off   = req_addr[1:0];
  assign req_err   = access_error(req_size, req_off);
  assign req_ready = (state == ST_IDLE);

  // Replicate narrow store data across every lane; the byte enables pick the target.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign store_data[i] = (req_size == MEM_SIZE_BYTE) ? req_wdata[7:0] :
                           (req_size == MEM_SIZE_HALF) ? req_wdata[LANE_W*(i%2) +: LANE_W] :
                                                         req_wdata[LANE_W*i +: LANE_W];
  end

  mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata     (ram_read_data),
    .offset    (req_q.offset),
    .size      (req_q.size),
    .is_signed (req_q.is_signed),
    .data      (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      req_q          <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      ram_en         <= 1'b0;
      ram_write_en   <= '0;
      ram_addr       <= '0;
      ram_write_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q <= '{write: req_write, size: req_size, is_signed: req_signed, offset: req_off};
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
              state      <= ST_RESP;
            end else begin
              ram_en         <= 1'b1;
              ram_addr       <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              ram_write_en   <= req_write ? lane_mask(req_size, req_off) : 4'b0000;
              ram_write_data <= req_write ? store_data : '0;
              state          <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          ram_en         <= 1'b0;
          ram_write_en   <= '0;
          ram_addr       <= '0;
          ram_write_data <= '0;
          if (req_q.write) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state      <= ST_RESP;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side data-memory controller that drives the synchronous data RAM port (enable, 4-bit byte write enable, address, write data, one-cycle registered read data). It accepts byte/halfword/word load and store requests from the CPU memory stage over a valid/ready handshake. It generates byte lanes and replicated write data, waits out the RAM read latency, aligns and sign- or zero-extends load data, and flags misaligned or illegal accesses without touching the RAM.

## Interface
Parameters:
- ADDR_WIDTH, 32, request and RAM address width; matches `ADDR_BUS.
- DATA_WIDTH, 32, data width; matches `DATA_BUS. Must be 32, since the lane logic is 4 bytes wide.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_WIDTH  formatted load data; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request.
- ram_en  out  1  RAM enable.
- ram_write_en  out  4  RAM byte write enables; bit i selects bits [8i+7:8i].
- ram_addr  out  ADDR_WIDTH  word-aligned RAM address.
- ram_write_data  out  DATA_WIDTH  RAM write data.
- ram_read_data  in  DATA_WIDTH  RAM read data; valid the cycle after a read is issued.

## Operation
States:
- IDLE: req_ready=1. On req_valid, latch the request. Then:
  - If the request has an error, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: drive ram_en=1, ram_addr={addr[31:2],2'b00}, and the byte lanes and data below.
  - Store: go to RESP (the write commits at this edge).
  - Load: ram_write_en=0; go to CAPTURE.
- CAPTURE: sample ram_read_data, format it into resp_rdata, go to RESP.
- RESP: resp_valid=1 and outputs held stable until resp_ready; then go to IDLE.

Error rules (checked in IDLE, no RAM access, resp_error=1, resp_rdata=0):
- size 11;
- halfword with addr[0]=1;
- word with addr[1:0]≠0.

Store lanes:
- byte: write_en = 4'b0001<<addr[1:0], data = {4{wdata[7:0]}}.
- half: write_en = 4'b0011<<{addr[1],1'b0}, data = {2{wdata[15:0]}}.
- word: write_en = 4'b1111, data = wdata.

Load formatting:
- byte: ram_read_data >> (8·addr[1:0]), low 8 bits, extended per req_signed.
- half: >> (16·addr[1]), low 16 bits, extended.
- word: unchanged; req_signed ignored.

Outside ISSUE: ram_en, ram_write_en, ram_addr and ram_write_data are all 0.

## Timing
- Reset values:
  - state IDLE, req_ready=1;
  - resp_valid=0, resp_rdata=0, resp_error=0;
  - ram_en=0, ram_write_en=0, ram_addr=0, ram_write_data=0.
- All outputs are registered except req_ready, which is decoded from state.
- Latency from the handshake cycle C0 to the first resp_valid cycle:
  - load: 3 cycles (C1 ISSUE, C2 CAPTURE, C3 RESP);
  - store: 2 cycles;
  - error: 1 cycle.
- Throughput: at most one outstanding request. The next request can be accepted the cycle after the RESP handshake.
- resp_valid held with resp_ready low: the response stays stable indefinitely, and req_ready stays 0.
- Reset mid-operation:
  - all outputs clear immediately (asynchronous);
  - if reset is asserted during ISSUE, ram_en drops before the edge, so no partial write commits;
  - a pending response is discarded.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.

## Structure
- Shared header next to bus.v holds:
  - size encodings (`MEM_SIZE_BYTE/HALF/WORD);
  - state encodings.
- Widths come from bus.v (`ADDR_BUS, `DATA_BUS, `MEM_SEL_BUS).
- One combinational sub-module, mem_load_align (rdata, offset, size, signed → formatted data), keeps extraction and extension separately testable. Write-lane generation stays inline.

## Test plan
- Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 → ISSUE shows ram_write_en=1111; load returns resp_rdata=0xDEADBEEF exactly 3 cycles after the handshake, resp_error=0.
- Byte store 0x80 to addr 0x13, then signed byte load 0x13 → ram_write_en=1000, ram_write_data=0x80808080; load returns 0xFFFFFF80. An unsigned load of the same byte returns 0x00000080.
- Half store 0x8001 to 0x22, then signed half load 0x22 → ram_write_en=1100; load returns 0xFFFF8001. A word load at 0x20 shows bits [31:16]=0x8001.
- Half load addr 0x21, word store addr 0x22, size 11 → each gives resp_error=1, resp_rdata=0 one cycle after the handshake; ram_en never asserts.
- Load completes, resp_ready held low 5 cycles, new req_valid asserted meanwhile → resp_valid and data stable for 5 cycles, req_ready=0, second request accepted only after the response handshake.
- rst pulsed during the ISSUE cycle of a word store 0x12345678 to 0x40 → all outputs 0 immediately; a later load of 0x40 returns the prior contents, not 0x12345678.
